// File: rtl/gate_truth_table_tester.sv
// gate_truth_table_tester: sweeps every minterm into an N_IN-input gate, samples its output after SETTLE cycles, and scores the observed truth table against EXPECT. Ports: clk, rst_n (async active-low), start in; dut_in out, dut_out in; busy, done, table_out, err_count, first_err, first_err_valid, match out. Define GATE_TESTER_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module gate_truth_table_tester #(
  parameter int N_IN = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0111,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  table_out,
  output logic [N_IN:0]         err_count,
  output logic [N_IN-1:0]       first_err,
  output logic                  first_err_valid,
  output logic                  match
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t r_state;
  logic [N_IN-1:0] r_m;
  logic [15:0] r_settle;
  logic w_miss, w_last;
  logic [N_IN:0] w_err_next;
  always_comb begin
    w_miss = dut_out != EXPECT[r_m];
    w_err_next = err_count + (N_IN+1)'(w_miss);
`ifdef GATE_TESTER_STOP_ON_ERR_EN
    w_last = (r_m == N_IN'((1<<N_IN)-1)) || w_miss;
`else
    w_last = r_m == N_IN'((1<<N_IN)-1);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_m <= '0;
      r_settle <= '0;
      dut_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      table_out <= '0;
      err_count <= '0;
      first_err <= '0;
      first_err_valid <= 1'b0;
      match <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          table_out <= '0;
          err_count <= '0;
          first_err <= '0;
          first_err_valid <= 1'b0;
          match <= 1'b0;
          r_m <= '0;
          dut_in <= '0;
          r_settle <= '0;
          busy <= 1'b1;
          r_state <= DRIVE;
        end
        DRIVE: if (r_settle == 16'(SETTLE-1)) begin
          r_settle <= '0;
          r_state <= SAMPLE;
        end else r_settle <= r_settle + 16'd1;
        SAMPLE: begin
          table_out[r_m] <= dut_out;
          err_count <= w_err_next;
          if (w_miss && !first_err_valid) begin
            first_err <= r_m;
            first_err_valid <= 1'b1;
          end
          if (w_last) begin
            done <= 1'b1;
            match <= w_err_next == '0;
            r_state <= DONE;
          end else begin
            r_m <= r_m + 1'b1;
            dut_in <= r_m + 1'b1;
            r_state <= DRIVE;
          end
        end
        default: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
endmodule
